// File: rtl/uart_tx_drain.sv
// 8N1 UART transmitter that drains a first-word-fall-through FIFO; pops on the frame's last cycle, tx falls one edge after the pop.
// Optional even-parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic bit_end;
    logic frame_last;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        bit_end    = (bit_cnt_q == '0);
        frame_last = (state_q == S_STOP) && bit_end && (stop_idx_q == STOP_LAST);
        tx_done    = rst_n && frame_last;
        fifo_rd_en = rst_n && !fifo_empty && ((state_q == S_IDLE) || frame_last);

        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_end ? BIT_LAST : bit_cnt_q - 1'b1;
        end

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = S_PARITY;
`else
                        state_d    = S_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A pop overrides the frame-end return to IDLE so frames run back-to-back.
        if (fifo_rd_en) begin
            state_d   = S_START;
            bit_cnt_d = BIT_LAST;
            shreg_d   = fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_d     = ^fifo_dout;
`endif
        end

        // tx is registered: drive the level belonging to the state being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            shreg_q    <= 8'h00;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: two instances (1 and 2 stop bits) each fed by a queue-backed FWFT FIFO model.
module tb_uart_tx_drain;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL1 = (10 + PAR) * CPB;
    localparam int FL2 = (11 + PAR) * CPB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dout1 = 8'h00;
    logic [7:0] dout2 = 8'h00;
    logic       empty1 = 1'b1;
    logic       empty2 = 1'b1;
    logic       rd_en1, tx1, busy1, done1;
    logic       rd_en2, tx2, busy2, done2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int npop1       = 0;
    int npop2       = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int         pop_cyc1[$];
    logic [7:0] pop_dat1[$];
    int         pop_cyc2[$];

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout1), .fifo_empty(empty1),
        .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout2), .fifo_empty(empty2),
        .fifo_rd_en(rd_en2), .tx(tx2), .busy(busy2), .tx_done(done2)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        if (PAR == 1 && n == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic refresh();
        empty1 = (q1.size() == 0);
        dout1  = (q1.size() > 0) ? q1[0] : 8'h00;
        empty2 = (q2.size() == 0);
        dout2  = (q2.size() > 0) ? q2[0] : 8'h00;
    endtask

    // Advance one cycle: log pops seen before the edge, retire them after it, return at negedge.
    task automatic tick();
        logic p1, p2;
        #1;
        p1 = rd_en1;
        p2 = rd_en2;
        if (p1) begin npop1++; pop_cyc1.push_back(cyc); pop_dat1.push_back(dout1); end
        if (p2) begin npop2++; pop_cyc2.push_back(cyc); end
        @(posedge clk);
        cyc++;
        #1;
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        if (p2 && q2.size() > 0) void'(q2.pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic wait_pop1(input int n0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (npop1 > n0) ok = 1'b1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL pop_timeout1: saw %0d pops, required %0d", npop1 - n0, 1);
        end
    endtask

    task automatic test_reset();
        tick(); tick(); tick();
        vectors++;
        if ({tx1, busy1, rd_en1, done1} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_hold: tx/busy/rd/done=%b required 1000", {tx1, busy1, rd_en1, done1});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            vectors++;
            if ({tx1, busy1, rd_en1, tx2, busy2, rd_en2} !== 6'b100100) begin
                miscompares++;
                $display("FAIL idle_empty cyc %0d: got %b required 100100", k,
                         {tx1, busy1, rd_en1, tx2, busy2, rd_en2});
            end
        end
    endtask

    task automatic test_single();
        int  n0, done_cnt, done_at, p;
        bit  ok;
        logic e;
        n0 = npop1; done_cnt = 0; done_at = -1;
        q1.push_back(8'h55); refresh();
        wait_pop1(n0, ok);
        if (!ok) return;
        p = pop_cyc1[$];
        for (int k = 1; k <= FL1 + 4; k++) begin
            if (k > 1) tick();
            e = (k <= FL1) ? exp_bit(8'h55, (k - 1) / CPB) : 1'b1;
            vectors++;
            if (tx1 !== e) begin
                miscompares++;
                $display("FAIL single_tx k=%0d: got %b required %b", k, tx1, e);
            end
            if (done1 === 1'b1) begin done_cnt++; done_at = cyc - p; end
        end
        vectors++;
        if (npop1 - n0 !== 1) begin miscompares++; $display("FAIL single_pops: got %0d required 1", npop1 - n0); end
        vectors++;
        if (done_cnt !== 1 || done_at !== FL1) begin
            miscompares++;
            $display("FAIL single_done: %0d pulses at %0d, required 1 at %0d", done_cnt, done_at, FL1);
        end
        vectors++;
        if (busy1 !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b required 0", busy1); end
    endtask

    task automatic test_back_to_back();
        int  n0, done_cnt, p;
        bit  ok;
        logic e, eb;
        n0 = npop1; done_cnt = 0;
        q1.push_back(8'hA3); q1.push_back(8'h0F); refresh();
        wait_pop1(n0, ok);
        if (!ok) return;
        p = pop_cyc1[$];
        for (int k = 1; k <= 2 * FL1 + 4; k++) begin
            if (k > 1) tick();
            if (k <= FL1)          e = exp_bit(8'hA3, (k - 1) / CPB);
            else if (k <= 2 * FL1) e = exp_bit(8'h0F, (k - FL1 - 1) / CPB);
            else                   e = 1'b1;
            eb = (k <= 2 * FL1);
            vectors++;
            if (tx1 !== e || busy1 !== eb) begin
                miscompares++;
                $display("FAIL b2b_line k=%0d: tx/busy=%b%b required %b%b", k, tx1, busy1, e, eb);
            end
            if (done1 === 1'b1) done_cnt++;
        end
        vectors++;
        if (npop1 - n0 !== 2 || pop_cyc1[$] - p !== FL1) begin
            miscompares++;
            $display("FAIL b2b_pops: %0d pops, gap %0d, required 2 pops gap %0d", npop1 - n0, pop_cyc1[$] - p, FL1);
        end
        vectors++;
        if (pop_dat1[$-1] !== 8'hA3 || pop_dat1[$] !== 8'h0F) begin
            miscompares++;
            $display("FAIL b2b_order: got %h %h required a3 0f", pop_dat1[$-1], pop_dat1[$]);
        end
        vectors++;
        if (done_cnt !== 2) begin miscompares++; $display("FAIL b2b_done: got %0d required 2", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int  n0, done_cnt, done_at, p, p2;
        bit  ok;
        logic e;
        n0 = npop1; done_cnt = 0; done_at = -1;
        q1.push_back(8'hFF); q1.push_back(8'h3C); refresh();
        wait_pop1(n0, ok);
        if (!ok) return;
        p = pop_cyc1[$];
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) tick();
            if (done1 === 1'b1) done_cnt++;
            if (k == 18) rst_n = 1'b0;
        end
        vectors++;
        if ({tx1, busy1, rd_en1, done1} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rst_mid: tx/busy/rd/done=%b required 1000", {tx1, busy1, rd_en1, done1});
        end
        vectors++;
        if (done_cnt !== 0) begin miscompares++; $display("FAIL rst_mid_done: got %0d required 0", done_cnt); end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (npop1 - n0 !== 2 || pop_dat1[$] !== 8'h3C) begin
            miscompares++;
            $display("FAIL rst_repop: %0d pops last %h, required 2 pops last 3c", npop1 - n0, pop_dat1[$]);
            return;
        end
        p2 = pop_cyc1[$];
        vectors++;
        if (p2 - p !== 19) begin miscompares++; $display("FAIL rst_pop_cycle: got %0d required 19", p2 - p); end
        for (int k = 1; k <= FL1 + 2; k++) begin
            if (k > 1) tick();
            e = (k <= FL1) ? exp_bit(8'h3C, (k - 1) / CPB) : 1'b1;
            vectors++;
            if (tx1 !== e) begin
                miscompares++;
                $display("FAIL rst_next_frame k=%0d: got %b required %b", k, tx1, e);
            end
            if (done1 === 1'b1) done_at = cyc - p2;
        end
        vectors++;
        if (done_at !== FL1) begin miscompares++; $display("FAIL rst_next_done: got %0d required %0d", done_at, FL1); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic exp_frame [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        int  n0, done_at, p;
        bit  ok;
        logic e;
        n0 = npop1; done_at = -1;
        q1.push_back(8'h07); refresh();
        wait_pop1(n0, ok);
        if (!ok) return;
        p = pop_cyc1[$];
        for (int k = 1; k <= 48; k++) begin
            if (k > 1) tick();
            e = (k <= 44) ? exp_frame[(k - 1) / CPB] : 1'b1;
            vectors++;
            if (tx1 !== e) begin
                miscompares++;
                $display("FAIL parity_tx k=%0d: got %b required %b", k, tx1, e);
            end
            if (done1 === 1'b1) done_at = cyc - p;
        end
        vectors++;
        if (done_at !== 44) begin miscompares++; $display("FAIL parity_done: got %0d required 44", done_at); end
    endtask
`endif

    task automatic test_two_stop();
        int  n0, done_cnt, done_at, p;
        bit  ok;
        logic e, eb;
        n0 = npop2; done_cnt = 0; done_at = -1; ok = 1'b0;
        q2.push_back(8'h00); refresh();
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (npop2 > n0) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stop2_pop_timeout: saw 0 pops, required 1");
            return;
        end
        p = pop_cyc2[$];
        for (int k = 1; k <= FL2 + 4; k++) begin
            if (k > 1) tick();
            e  = (k <= (9 + PAR) * CPB) ? 1'b0 : 1'b1;
            eb = (k <= FL2);
            vectors++;
            if (tx2 !== e || busy2 !== eb) begin
                miscompares++;
                $display("FAIL stop2_line k=%0d: tx/busy=%b%b required %b%b", k, tx2, busy2, e, eb);
            end
            if (done2 === 1'b1) begin done_cnt++; done_at = cyc - p; end
        end
        vectors++;
        if (done_cnt !== 1 || done_at !== FL2) begin
            miscompares++;
            $display("FAIL stop2_done: %0d pulses at %0d, required 1 at %0d", done_cnt, done_at, FL2);
        end
    endtask

    initial begin
        refresh();
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_two_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
